// File: rtl/down_counter_timer_ctrl.sv
// Sequencing controller for a mod-N down counter: load, start, pause, abort,
// one-shot or auto-reload operation, with a one-cycle expiry pulse.
module down_counter_timer_ctrl #(
    parameter  int MOD_VALUE = 32,
    localparam int W         = $clog2(MOD_VALUE)
) (
    input  logic         clk,
    input  logic         rst,
    // load_valid/load_ready: a reload value transfers on any rising edge
    // where both are high; load_ready depends only on state, never on load_valid.
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [W-1:0] load_value,
    input  logic         start,
    input  logic         pause,
    input  logic         abort,
    input  logic         auto_reload,
    output logic [W-1:0] count,
    output logic         busy,
    output logic         expired,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam logic [W:0]   MOD_EXT = (W + 1)'(MOD_VALUE);
    localparam logic [W-1:0] MAX_CNT = W'(MOD_VALUE - 1);

    state_e       state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] reload_q, reload_d;
    logic         expired_q, expired_d;

    logic         load_fire;
    logic [W-1:0] load_clamped;

    // Out-of-range values can only arrive when MOD_VALUE is not a power of two.
    assign load_clamped = ({1'b0, load_value} >= MOD_EXT) ? MAX_CNT : load_value;
    assign load_fire    = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            reload_q  <= MAX_CNT;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            expired_q <= expired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = load_fire ? load_clamped : reload_q;
        expired_d = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                // A load accepted on the start edge wins over the stored value.
                if (start) begin
                    count_d = load_fire ? load_clamped : reload_q;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (pause) begin
                    state_d = S_PAUSED;
                end else if (count_q != '0) begin
                    count_d = count_q - W'(1);
                end else begin
                    expired_d = 1'b1;
                    if (auto_reload) begin
                        count_d = reload_q;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_PAUSED: begin
                // Resuming costs one edge with no decrement.
                if (abort) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (!pause) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == S_RUN) || (state_q == S_PAUSED);
        load_ready = (state_q == S_IDLE) || (state_q == S_DONE);
    end

    assign count   = count_q;
    assign expired = expired_q;
    assign state   = state_q;

endmodule
